// File: rtl/arbitro_escrita_banco.sv
// arbitro_escrita_banco: two-requester write-port arbiter in front of the register bank.
// Requester A (load writeback) and requester B (ALU writeback) compete for a single
// registered write port. The grant is combinational, and the bank write happens one
// cycle after the transfer edge. Writes to register 26 ($zero) are accepted but
// never written.
// Optional feature: define ARB_ROUND_ROBIN_EN to replace fixed priority A (with a B
// starvation limit of 3) by a 1-bit round-robin pointer. espera_b then reads 0.
module arbitro_escrita_banco (
  input  logic        clk,
  input  logic        rst,
  input  logic        val_a,
  input  logic [4:0]  resc_a,
  input  logic [31:0] dado_a,
  output logic        pronto_a,
  input  logic        val_b,
  input  logic [4:0]  resc_b,
  input  logic [31:0] dado_b,
  output logic        pronto_b,
  input  logic        congela,
  output logic        h_esc,
  output logic [4:0]  resc,
  output logic [31:0] dado,
  output logic [1:0]  espera_b
);

  localparam logic [4:0] RESC_ZERO = 5'd26;

  logic        contested;
  logic        prefer_b;
  logic        xfer;
  logic [4:0]  resc_sel;
  logic [31:0] dado_sel;

  assign contested = val_a & val_b;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  assign prefer_b = rr_ptr;
  assign espera_b = 2'd0;

  // Round-robin pointer: flips after every contested grant; freeze holds it.
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (contested && !congela)
      rr_ptr <= ~rr_ptr;
  end
`else
  logic [1:0] espera_q;

  assign prefer_b = (espera_q == 2'd3);
  assign espera_b = espera_q;

  // Starvation counter for B: counts contested losses, cleared by any B grant, saturates at 3.
  always_ff @(posedge clk) begin
    if (rst)
      espera_q <= 2'd0;
    else if (pronto_b)
      espera_q <= 2'd0;
    else if (pronto_a && contested && (espera_q != 2'd3))
      espera_q <= espera_q + 2'd1;
  end
`endif

  // Grant logic: nothing is accepted during reset or freeze; at most one grant per cycle.
  always_comb begin
    pronto_a = 1'b0;
    pronto_b = 1'b0;
    if (!rst && !congela) begin
      if (val_a && (!val_b || !prefer_b))
        pronto_a = 1'b1;
      if (val_b && (!val_a || prefer_b))
        pronto_b = 1'b1;
    end
  end

  assign xfer     = pronto_a | pronto_b;
  assign resc_sel = pronto_b ? resc_b : resc_a;
  assign dado_sel = pronto_b ? dado_b : dado_a;

  // Write port register: capture the granted request; a write to $zero is accepted but not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_esc <= 1'b0;
      resc  <= 5'd0;
      dado  <= 32'd0;
    end else if (xfer) begin
      h_esc <= (resc_sel != RESC_ZERO);
      resc  <= resc_sel;
      dado  <= dado_sel;
    end else begin
      h_esc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Directed, table-driven bench for arbitro_escrita_banco (either build configuration).
module tb_arbitro_escrita_banco;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, congela;
  logic        val_a, val_b;
  logic [4:0]  resc_a, resc_b;
  logic [31:0] dado_a, dado_b;
  logic        pronto_a, pronto_b, h_esc;
  logic [4:0]  resc;
  logic [31:0] dado;
  logic [1:0]  espera_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  arbitro_escrita_banco dut (
    .clk(clk), .rst(rst),
    .val_a(val_a), .resc_a(resc_a), .dado_a(dado_a), .pronto_a(pronto_a),
    .val_b(val_b), .resc_b(resc_b), .dado_b(dado_b), .pronto_b(pronto_b),
    .congela(congela), .h_esc(h_esc), .resc(resc), .dado(dado), .espera_b(espera_b)
  );

  typedef struct {
    logic        rst, congela, val_a, val_b;
    logic [4:0]  resc_a, resc_b;
    logic [31:0] dado_a, dado_b;
    logic        e_pa, e_pb, e_h;
    logic [4:0]  e_resc;
    logic [31:0] e_dado;
    logic [1:0]  e_esp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic cg, logic va, logic [4:0] ra, logic [31:0] da,
                              logic vb, logic [4:0] rb, logic [31:0] db,
                              logic pa, logic pb, logic h, logic [4:0] er,
                              logic [31:0] ed, logic [1:0] ee);
    vec_t v;
    v.rst = r; v.congela = cg; v.val_a = va; v.resc_a = ra; v.dado_a = da;
    v.val_b = vb; v.resc_b = rb; v.dado_b = db;
    v.e_pa = pa; v.e_pb = pb; v.e_h = h; v.e_resc = er; v.e_dado = ed; v.e_esp = ee;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic r, logic cg, logic va, logic [4:0] ra, logic [31:0] da,
                       logic vb, logic [4:0] rb, logic [31:0] db);
    rst = r; congela = cg; val_a = va; resc_a = ra; dado_a = da;
    val_b = vb; resc_b = rb; dado_b = db;
  endtask

  // Contested grant sequence expected by the bench for each build.
  function automatic logic grant_b(int k);
    if (RR) return (k % 2) == 1;
    return k == 3;
  endfunction

  initial begin
    logic [1:0] esp_fx [5];
    logic [1:0] e_hold;
    logic [1:0] seq_esp [4];
    logic       seq_gb  [4];

    esp_fx[0] = 2'd1; esp_fx[1] = 2'd2; esp_fx[2] = 2'd3; esp_fx[3] = 2'd0; esp_fx[4] = 2'd1;

    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // reset with a pending request: discarded
    vecs.push_back(mk(1,0, 1,5'd3,32'h1, 0,5'd0,32'h0,  0,0, 0,5'd0,32'h0, 2'd0));
    // only B, resc 5 / 0xAA
    vecs.push_back(mk(0,0, 0,5'd0,32'h0, 1,5'd5,32'hAA, 0,1, 1,5'd5,32'hAA, 2'd0));
    // idle: outputs held, no write
    vecs.push_back(mk(0,0, 0,5'd0,32'h0, 0,5'd0,32'h0,  0,0, 0,5'd5,32'hAA, 2'd0));
    // five contested edges
    for (int k = 0; k < 5; k++) begin
      logic gb;
      gb = grant_b(k);
      vecs.push_back(mk(0,0, 1,5'd1,32'h11, 1,5'd2,32'h22, !gb,gb, 1,
                        gb ? 5'd2 : 5'd1, gb ? 32'h22 : 32'h11,
                        RR ? 2'd0 : esp_fx[k]));
    end
    e_hold = RR ? 2'd0 : 2'd1;
    // freeze for two cycles with both valid (last grant was A in both builds)
    for (int k = 0; k < 2; k++)
      vecs.push_back(mk(0,1, 1,5'd1,32'h11, 1,5'd2,32'h22, 0,0, 0,5'd1,32'h11, e_hold));
    // write to $zero accepted but not written
    vecs.push_back(mk(0,0, 1,5'd26,32'hFFFF_FFFF, 0,5'd0,32'h0, 1,0, 0,5'd26,32'hFFFF_FFFF, e_hold));
    // A writes r7, then reset the next cycle while both request
    vecs.push_back(mk(0,0, 1,5'd7,32'h77, 0,5'd0,32'h0, 1,0, 1,5'd7,32'h77, e_hold));
    vecs.push_back(mk(1,0, 1,5'd8,32'h88, 1,5'd9,32'h99, 0,0, 0,5'd0,32'h0, 2'd0));
    // first edge after reset: A wins (counter / pointer reset)
    vecs.push_back(mk(0,0, 1,5'd1,32'h11, 1,5'd2,32'h22, 1,0, 1,5'd1,32'h11, RR ? 2'd0 : 2'd1));
    // B alone to $zero: accepted, no write, clears starvation count
    vecs.push_back(mk(0,0, 0,5'd0,32'h0, 1,5'd26,32'h22, 0,1, 0,5'd26,32'h22, 2'd0));
    vecs.push_back(mk(0,0, 0,5'd0,32'h0, 0,5'd0,32'h0,  0,0, 0,5'd26,32'h22, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].congela, vecs[i].val_a, vecs[i].resc_a, vecs[i].dado_a,
            vecs[i].val_b, vecs[i].resc_b, vecs[i].dado_b);
      #1;
      chk($sformatf("v%0d pronto_a", i), {31'd0, pronto_a}, {31'd0, vecs[i].e_pa});
      chk($sformatf("v%0d pronto_b", i), {31'd0, pronto_b}, {31'd0, vecs[i].e_pb});
      @(posedge clk); #1;
      chk($sformatf("v%0d h_esc", i),    {31'd0, h_esc},    {31'd0, vecs[i].e_h});
      chk($sformatf("v%0d resc", i),     {27'd0, resc},     {27'd0, vecs[i].e_resc});
      chk($sformatf("v%0d dado", i),     dado,              vecs[i].e_dado);
      chk($sformatf("v%0d espera_b", i), {30'd0, espera_b}, {30'd0, vecs[i].e_esp});
    end

    // Hand sequence: freeze in the middle of a contested run must not advance arbitration.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    chk("seq reset espera_b", {30'd0, espera_b}, 32'd0);
    if (RR) begin
      seq_gb[0] = 0; seq_gb[1] = 1; seq_gb[2] = 0; seq_gb[3] = 1;
      seq_esp[0] = 0; seq_esp[1] = 0; seq_esp[2] = 0; seq_esp[3] = 0;
    end else begin
      seq_gb[0] = 0; seq_gb[1] = 0; seq_gb[2] = 0; seq_gb[3] = 1;
      seq_esp[0] = 1; seq_esp[1] = 2; seq_esp[2] = 3; seq_esp[3] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        #1;
        chk("seq freeze pronto", {30'd0, pronto_a, pronto_b}, 32'd0);
        @(posedge clk); #1;
        chk("seq freeze h_esc", {31'd0, h_esc}, 32'd0);
        chk("seq freeze espera_b", {30'd0, espera_b}, {30'd0, seq_esp[1]});
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      #1;
      chk($sformatf("seq%0d grant", k), {30'd0, pronto_a, pronto_b},
          {30'd0, !seq_gb[k], seq_gb[k]});
      @(posedge clk); #1;
      chk($sformatf("seq%0d resc", k), {27'd0, resc}, seq_gb[k] ? 32'd4 : 32'd3);
      chk($sformatf("seq%0d h_esc", k), {31'd0, h_esc}, 32'd1);
      chk($sformatf("seq%0d espera_b", k), {30'd0, espera_b}, {30'd0, seq_esp[k]});
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    chk("seq tail h_esc", {31'd0, h_esc}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbitro_escrita_banco.md
ARBITRO_ESCRITA_BANCO -- requirements
Module: arbitro_escrita_banco

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: val_a  input  1  requester A (load writeback) write request valid.
REQ-004 SHALL have port: resc_a  input  5  requester A destination register address.
REQ-005 SHALL have port: dado_a  input  32  requester A write data.
REQ-006 SHALL have port: pronto_a  output  1  requester A accepted this cycle (combinational).
REQ-007 SHALL have ports val_b, resc_b, dado_b, pronto_b with identical widths and meaning for requester B (ALU writeback).
REQ-008 SHALL have port: congela  input  1  pipeline freeze; blocks all acceptance while high.
REQ-009 SHALL have port: h_esc  output  1  registered write enable to register bank.
REQ-010 SHALL have port: resc  output  5  registered write address to register bank.
REQ-011 SHALL have port: dado  output  32  registered write data to register bank.
REQ-012 SHALL have port: espera_b  output  2  current count of consecutive contested cycles B has lost.

Function
REQ-013 SHALL transfer a request when val_x and pronto_x are both 1 at a rising clk edge.
REQ-014 SHALL assert at most one of pronto_a/pronto_b in any cycle.
REQ-015 SHALL hold pronto_x at 0 whenever val_x=0, congela=1 or rst=1.
REQ-016 SHALL, with exactly one valid requester and congela=0, assert that requester's pronto.
REQ-017 SHALL, when both are valid (contested) and congela=0, grant A unless espera_b=3, in which case grant B.
REQ-018 SHALL increment espera_b on each contested edge granted to A; clear it on any edge granting B; hold it otherwise (including congela=1); saturate at 3 (never wrap).
REQ-019 SHALL register the granted resc_x/dado_x into resc/dado at the transfer edge, giving one-cycle latency: bank writes at the following edge.
REQ-020 SHALL set h_esc=1 for exactly the cycle after a transfer whose address is not 26, and 0 otherwise.
REQ-021 SHALL accept (pronto=1) a request addressed to 26 ($zero) but keep h_esc=0, so x[26] is never written.
REQ-022 SHALL hold resc/dado unchanged on cycles with no transfer; h_esc=0 on those cycles.
REQ-023 SHALL support back-to-back transfers on consecutive edges without bubbles.
REQ-024 SHALL require requesters to hold val_x, resc_x, dado_x stable until pronto_x seen; arbiter does not buffer refused requests.

Reset
REQ-025 SHALL, on an edge with rst=1, set h_esc=0, resc=0, dado=0, espera_b=0.
REQ-026 SHALL discard any request presented during reset (pronto_x=0), including reset asserted mid-burst; no write issued the cycle after reset.
REQ-027 SHALL resume normal arbitration on the first edge after rst returns to 0.

Configuration
REQ-028 SHALL, with macro ARB_ROUND_ROBIN_EN defined, replace REQ-017/018 with a 1-bit round-robin pointer (reset to A) that toggles to the other requester after each contested grant; espera_b then reads constant 0.
REQ-029 SHALL, without ARB_ROUND_ROBIN_EN, implement fixed priority A with starvation limit 3 per REQ-017/018.

Verification
REQ-030 SHALL cover: only val_b=1, resc_b=5, dado_b=0x0000_00AA -> pronto_b=1; next cycle h_esc=1, resc=5, dado=0xAA.
REQ-031 SHALL cover: val_a=val_b=1 for 5 edges (fixed priority) -> grants A,A,A,B,A; espera_b 1,2,3,0,1.
REQ-032 SHALL cover: val_a=1, resc_a=26, dado_a=0xFFFF_FFFF -> pronto_a=1; next cycle h_esc=0.
REQ-033 SHALL cover: congela=1 with both valid for 2 cycles -> pronto_a=pronto_b=0, h_esc=0, espera_b unchanged.
REQ-034 SHALL cover: rst=1 asserted the cycle after an A transfer to resc 7 -> h_esc=0, resc=0, dado=0 after that edge.
REQ-035 SHALL cover: ARB_ROUND_ROBIN_EN defined, both valid 4 edges -> grants A,B,A,B.
